// File: rtl/add_a_b_cin_pipe.sv
// add_a_b_cin_pipe: pipelined adder out = a + b + cin.
// The add is split into SEGS equal segments, and each segment is one pipeline
// stage. A 2-bit carry is registered between stages. The operand bits that are
// not yet added travel with the partial sum. The whole pipeline advances
// together, and it stalls when the consumer applies backpressure.
module add_a_b_cin_pipe #(
  parameter int SIZE  = 32,
  parameter int SEGS  = 4,
  parameter int CIN_W = 2
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  input  logic [CIN_W-1:0]  cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE+1:0]   out
);

  localparam int SW = SIZE / SEGS;

  logic adv;

  genvar k;
  for (k = 0; k < SEGS; k++) begin : g_stage
    logic [SW-1:0]         a_seg;
    logic [SW-1:0]         b_seg;
    logic [SW+1:0]         addend;
    logic [SW+1:0]         seg_s;
    logic [(k+1)*SW-1:0]   sum_d;
    logic [(k+1)*SW-1:0]   sum_p;
    logic [1:0]            cy_p;
    logic                  vld_d;
    logic                  vld_p;

    // ---- stage k input: port inputs for k=0, previous stage register otherwise
    if (k == 0) begin : g_src
      assign a_seg  = a[SW-1:0];
      assign b_seg  = b[SW-1:0];
      assign addend = {{(SW+2-CIN_W){1'b0}}, cin};
      assign vld_d  = in_valid;
      assign sum_d  = seg_s[SW-1:0];
    end else begin : g_src
      assign a_seg  = g_stage[k-1].g_ops.a_p[SW-1:0];
      assign b_seg  = g_stage[k-1].g_ops.b_p[SW-1:0];
      assign addend = {{SW{1'b0}}, g_stage[k-1].cy_p};
      assign vld_d  = g_stage[k-1].vld_p;
      assign sum_d  = {seg_s[SW-1:0], g_stage[k-1].sum_p};
    end

    // The carry-in is at most 2^SW-1, so the segment sum fits in SW+2 bits
    // and the carry-out is at most 2.
    assign seg_s = {2'b00, a_seg} + {2'b00, b_seg} + addend;

    // Stage k result register: valid, carry and finished sum segments.
    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        vld_p <= 1'b0;
        cy_p  <= '0;
        sum_p <= '0;
      end else if (adv) begin
        vld_p <= vld_d;
        cy_p  <= seg_s[SW+1:SW];
        sum_p <= sum_d;
      end
    end

    // ---- stage k operand carry: only the high segments not yet added move on
    if (k < SEGS-1) begin : g_ops
      localparam int HW = SIZE - (k+1)*SW;
      logic [HW-1:0] a_d;
      logic [HW-1:0] b_d;
      logic [HW-1:0] a_p;
      logic [HW-1:0] b_p;

      if (k == 0) begin : g_opsrc
        assign a_d = a[SIZE-1:SW];
        assign b_d = b[SIZE-1:SW];
      end else begin : g_opsrc
        assign a_d = g_stage[k-1].g_ops.a_p[HW+SW-1:SW];
        assign b_d = g_stage[k-1].g_ops.b_p[HW+SW-1:SW];
      end

      // Pending operand segments. These hold data only, so they are not reset.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_p <= a_d;
          b_p <= b_d;
        end
      end
    end
  end

  // ---- output: last stage register drives the stream output directly
  assign out_valid = g_stage[SEGS-1].vld_p;
  assign out       = {g_stage[SEGS-1].cy_p, g_stage[SEGS-1].sum_p};

  // The pipeline moves when the output slot is empty or is being taken.
  // There is no skid buffer, so in_ready follows out_ready combinationally.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

endmodule

// File: tb/tb_add_a_b_cin_pipe.sv
// Testbench for add_a_b_cin_pipe: an 8-bit/2-segment instance and a
// 32-bit/4-segment instance, with a queue-based scoreboard and vector tables.
module tb_add_a_b_cin_pipe;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [1:0]  c8;
  logic [9:0]  o8;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32;
  logic [1:0]  c32;
  logic [33:0] o32;

  add_a_b_cin_pipe #(.SIZE(8), .SEGS(2), .CIN_W(2)) u8 (
    .clk(clk), .aclr(aclr), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(c8), .out_valid(ov8), .out_ready(or8), .out(o8));

  add_a_b_cin_pipe #(.SIZE(32), .SEGS(4), .CIN_W(2)) u32 (
    .clk(clk), .aclr(aclr), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(c32), .out_valid(ov32), .out_ready(or32), .out(o32));

  typedef struct {logic [33:0] v; int cyc;} exp_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic [1:0] cin; logic [9:0] exp;} vec8_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic [1:0] cin; logic [33:0] exp;} vec32_t;

  exp_t   q8[$];
  exp_t   q32[$];
  vec8_t  t8[8];
  vec32_t t32[8];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit lat_chk = 1'b1;
  int stall_left = 0;
  bit rand_bp = 1'b0;
  bit saw_stall8 = 1'b0;
  bit stab8 = 1'b0;
  bit stab32 = 1'b0;
  logic [9:0]  prev8;
  logic [33:0] prev32;
  logic [33:0] cur_exp8, cur_exp32;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then move past the rising edge.
  task automatic step(output bit acc8, output bit acc32);
    exp_t e;
    @(negedge clk);
    acc8  = iv8 && ir8;
    acc32 = iv32 && ir32;
    chk("in_ready8", ir8, !ov8 || or8);
    chk("in_ready32", ir32, !ov32 || or32);
    if (stab8) begin
      chk("hold_valid8", ov8, 1);
      chk("hold_out8", o8, prev8);
    end
    if (stab32) begin
      chk("hold_valid32", ov32, 1);
      chk("hold_out32", o32, prev32);
    end
    if (ov8 && or8) begin
      if (q8.size() == 0) chk("spurious8", ov8, 0);
      else begin
        e = q8.pop_front();
        chk("out8", o8, e.v);
        if (lat_chk) chk("latency8", cyc, e.cyc + 2);
      end
    end
    if (ov32 && or32) begin
      if (q32.size() == 0) chk("spurious32", ov32, 0);
      else begin
        e = q32.pop_front();
        chk("out32", o32, e.v);
        if (lat_chk) chk("latency32", cyc, e.cyc + 4);
      end
    end
    if (ov8 && !or8) saw_stall8 = 1'b1;
    stab8  = ov8 && !or8;
    stab32 = ov32 && !or32;
    prev8  = o8;
    prev32 = o32;
    if (acc8)  q8.push_back('{v: cur_exp8, cyc: cyc});
    if (acc32) q32.push_back('{v: cur_exp32, cyc: cyc});
    @(posedge clk);
    cyc++;
    #1;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) or8 = 1'b1;
    end
    if (rand_bp) or32 = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    bit x, y;
    repeat (n) step(x, y);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                       input logic [9:0] e);
    bit x8, x32;
    int n;
    a8 = a; b8 = b; c8 = c; iv8 = 1'b1; cur_exp8 = {24'b0, e};
    n = 0;
    x8 = 1'b0;
    while (!x8 && n < 50) begin
      step(x8, x32);
      n++;
    end
    chk("accept8", x8, 1);
    iv8 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                        input logic [33:0] e);
    bit x8, x32;
    int n;
    a32 = a; b32 = b; c32 = c; iv32 = 1'b1; cur_exp32 = e;
    n = 0;
    x32 = 1'b0;
    while (!x32 && n < 50) begin
      step(x8, x32);
      n++;
    end
    chk("accept32", x32, 1);
    iv32 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q32.size() != 0) && n < 60) begin
      idle(1);
      n++;
    end
    chk("drain8", q8.size(), 0);
    chk("drain32", q32.size(), 0);
  endtask

  initial begin
    logic [7:0]  ra8, rb8;
    logic [31:0] ra32, rb32;
    logic [1:0]  rc;

    t8[0] = '{8'h12, 8'h34, 2'd3, 10'h049};
    t8[1] = '{8'hFF, 8'hFF, 2'd3, 10'h201};
    t8[2] = '{8'h00, 8'h00, 2'd0, 10'h000};
    t8[3] = '{8'hFF, 8'h00, 2'd0, 10'h0FF};
    t8[4] = '{8'h0F, 8'h01, 2'd0, 10'h010};
    t8[5] = '{8'h80, 8'h80, 2'd0, 10'h100};
    t8[6] = '{8'hFF, 8'hFF, 2'd0, 10'h1FE};
    t8[7] = '{8'h7F, 8'h01, 2'd2, 10'h082};

    t32[0] = '{32'h0000_0000, 32'h0000_0000, 2'd0, 34'h0_0000_0000};
    t32[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 34'h2_0000_0001};
    t32[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'd0, 34'h0_FFFF_FFFF};
    t32[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 34'h1_0000_0000};
    t32[4] = '{32'h0000_0000, 32'h0000_0000, 2'd3, 34'h0_0000_0003};
    t32[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 34'h1_FFFF_FFFE};
    t32[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 2'd1, 34'h0_ACF1_3569};
    t32[7] = '{32'h0000_FFFF, 32'h0000_0000, 2'd3, 34'h0_0001_0002};

    aclr = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; or8 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; c32 = '0; or32 = 1'b1;
    cur_exp8 = '0; cur_exp32 = '0; prev8 = '0; prev32 = '0;

    // Reset state
    #7;
    chk("rst_valid8", ov8, 0);
    chk("rst_out8", o8, 0);
    chk("rst_ready8", ir8, 1);
    chk("rst_valid32", ov32, 0);
    chk("rst_out32", o32, 0);
    chk("rst_ready32", ir32, 1);
    #5 aclr = 1'b0;
    @(posedge clk);
    #1;

    // Single transfer, latency 2, then bubble
    send8(8'h12, 8'h34, 2'd3, 10'h049);
    idle(4);

    // Vector table, back to back
    for (int i = 0; i < 8; i++) send8(t8[i].a, t8[i].b, t8[i].cin, t8[i].exp);
    idle(4);

    // 16 random back-to-back vectors
    for (int i = 0; i < 16; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 2'($urandom_range(0, 3));
      send8(ra8, rb8, rc, {2'b00, ra8} + {2'b00, rb8} + {8'b0, rc});
    end
    idle(4);

    // Backpressure: out_ready low for 5 cycles while 4 vectors stream in
    lat_chk = 1'b0;
    saw_stall8 = 1'b0;
    or8 = 1'b0;
    stall_left = 5;
    for (int i = 0; i < 4; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 2'($urandom_range(0, 3));
      send8(ra8, rb8, rc, {2'b00, ra8} + {2'b00, rb8} + {8'b0, rc});
    end
    drain();
    chk("stall_seen8", saw_stall8, 1);
    lat_chk = 1'b1;
    idle(2);

    // Mid-operation asynchronous reset with two vectors in flight
    send8(8'hA5, 8'h5A, 2'd1, 10'h100);
    send8(8'h33, 8'h44, 2'd2, 10'h079);
    #3 aclr = 1'b1;
    #1;
    chk("midrst_valid8", ov8, 0);
    chk("midrst_out8", o8, 0);
    chk("midrst_ready8", ir8, 1);
    q8.delete();
    stab8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4 aclr = 1'b0;
    cyc += 2;
    idle(4);
    send8(8'h01, 8'h01, 2'd1, 10'h003);
    idle(4);

    // 32-bit instance: corner table, then random stream
    for (int i = 0; i < 8; i++) send32(t32[i].a, t32[i].b, t32[i].cin, t32[i].exp);
    idle(6);
    for (int i = 0; i < 40; i++) begin
      ra32 = $urandom; rb32 = $urandom; rc = 2'($urandom_range(0, 3));
      send32(ra32, rb32, rc, {2'b00, ra32} + {2'b00, rb32} + {32'b0, rc});
    end
    idle(6);

    // 32-bit instance under random backpressure
    lat_chk = 1'b0;
    rand_bp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra32 = $urandom; rb32 = $urandom; rc = 2'($urandom_range(0, 3));
      send32(ra32, rb32, rc, {2'b00, ra32} + {2'b00, rb32} + {32'b0, rc});
    end
    rand_bp = 1'b0;
    or32 = 1'b1;
    drain();
    lat_chk = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/add_a_b_cin_pipe.md
Name: add_a_b_cin_pipe

Overview:
- Parametrised, pipelined successor to the fixed 2-bit-carry-in adder. Computes out = a + b + cin, where cin is a small multi-bit injected constant (0..2^CIN_W-1).
- The add is split into SEGS equal segments, one segment per pipeline stage. A 2-bit inter-segment carry is registered between stages.
- Sits between producer and consumer datapath stages as a valid/ready stream element. It stalls the whole pipeline under backpressure.

Parameters:
- SIZE, 32, operand width; SIZE % SEGS == 0.
- SEGS, 4, number of segments and pipeline stages (latency); 1 <= SEGS <= SIZE.
- CIN_W, 2, carry-in width; 1 <= CIN_W <= SIZE/SEGS.

Ports:
- clk  in  1  clock; all state on rising edge.
- aclr  in  1  asynchronous, active-high reset.
- in_valid  in  1  a/b/cin valid this cycle.
- in_ready  out  1  block accepts input this cycle.
- a  in  SIZE  operand.
- b  in  SIZE  operand.
- cin  in  CIN_W  injected carry value, unsigned.
- out_valid  out  1  out holds a result.
- out_ready  in  1  consumer accepts out this cycle.
- out  out  SIZE+2  full unsigned sum a+b+cin; the top 2 bits are the carry-out, value 0..2.

Behaviour:
- Interface decided: one clock clk; reset aclr is asynchronous and active-high.
- Segment width SW = SIZE/SEGS. Segment k covers bits [k*SW +: SW].
- Stage 0 computes a[seg0] + b[seg0] + cin in SW+2 bits. The low SW bits are the sum; the top 2 bits are the carry (0..2).
- Stage k (k >= 1) computes a[segk] + b[segk] + carry_{k-1}.
  - Carry never exceeds 2, because CIN_W <= SW.
  - A 2-bit carry register is therefore sufficient; no wider carry is permitted.
- Each stage register holds the following, so operands travel with their partial result:
  - finished low sum segments;
  - the not-yet-added high a/b segments;
  - the 2-bit carry;
  - a valid bit.
- The final stage output is out = {carry_{SEGS-1}, sum segments}.
- Pipeline advance: adv = ~out_valid | out_ready.
  - in_ready = adv; this is combinational from out_ready, with no skid buffer.
  - When adv=1, every stage loads from its predecessor, stage 0 loads from the inputs, and stage 0 valid <= in_valid.
  - When adv=0, all stage registers and valid bits hold.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency: a transfer accepted at cycle t produces out_valid at t+SEGS, given no stall. Throughput is 1 result per cycle.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0 slots. Stages with valid=0 may carry arbitrary data, but out_valid must be 0 for them.
- While out_valid=1 and out_ready=0, out and out_valid must stay stable every cycle until accepted.
- Reset, asynchronous on aclr assertion:
  - all valid bits, partial sums, carries and out go to 0;
  - out_valid=0 and in_ready=1 immediately;
  - in-flight data is discarded, not flushed;
  - after release, the first accepted input appears SEGS cycles later.
- Simultaneous output accept and input accept in the same cycle is the normal streaming case. Both complete, and no data is lost or duplicated.
- Wrap-around: none. The SIZE+2 output holds the exact sum, and no truncation occurs.
- SEGS=1 degenerates to a single registered adder with latency 1.

Test Plan:
- SIZE=8, SEGS=2, CIN_W=2, reset:
  - stimulus: a=0x12, b=0x34, cin=3, in_valid for 1 cycle, out_ready=1;
  - response: out=0x049 with out_valid high exactly 2 cycles after accept, then 0.
- Max carry chain, same config:
  - stimulus: a=0xFF, b=0xFF, cin=3;
  - response: out=0x201. The segment-0 carry is 2 (0xF+0xF+3=0x21), which checks the 2-bit carry path.
- Streaming:
  - stimulus: 16 back-to-back random vectors with out_ready=1;
  - response: 16 consecutive out_valid cycles, each matching a+b+cin in order, with in_ready constantly 1.
- Backpressure:
  - stimulus: stream 4 vectors, hold out_ready=0 for 5 cycles;
  - response: in_ready=0 while out_valid=1; out stays stable; all 4 results are delivered in order after release, with none lost or duplicated.
- Mid-operation reset:
  - stimulus: 2 vectors in flight, assert aclr asynchronously between edges;
  - response: out_valid=0 and out=0 immediately; no stale result appears after release; a new vector a=0x01, b=0x01, cin=1 yields out=0x003 at latency 2.
- Config SIZE=32, SEGS=4, CIN_W=2, random plus corner vectors (0 operands, all-ones operands, cin=0/3):
  - response: exact match against a reference model; latency 4.
